// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type, sizing helpers and output saturation for conv3x3_stream_layer
// CONV_RELU_EN selects fused-ReLU clamping in sat_res instead of signed saturation.
package conv_pkg;

  typedef enum logic [1:0] {
    ACCEPT  = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  localparam int TAPS = 9;

  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int acc_width(input int data_w, input int in_ch);
    return 2 * data_w + clog2(in_ch * TAPS) + 1;
  endfunction

  function automatic int wgt_count(input int in_ch, input int out_ch);
    return out_ch * in_ch * TAPS;
  endfunction

  function automatic logic [31:0] sat_res(input logic signed [63:0] v, input int data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
`ifdef CONV_RELU_EN
    hi = (64'sd1 <<< data_w) - 64'sd1;
    lo = 64'sd0;
`else
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
`endif
    if (v > hi) return hi[31:0];
    else if (v < lo) return lo[31:0];
    else return v[31:0];
  endfunction

endpackage

// File: rtl/line_window_buf.sv
// rtl/line_window_buf.sv - two column-indexed line buffers feeding a 3x3 multi-channel shift window
module line_window_buf import conv_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int IN_CH  = 3,
  parameter int IMG_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_shift,
  input  logic                              i_sof,
  input  logic [clog2(IMG_W)-1:0]           i_col,
  input  logic [IN_CH*DATA_W-1:0]           i_pix,
  output logic [TAPS*IN_CH*DATA_W-1:0]      o_win
);
  localparam int PIX_W = IN_CH * DATA_W;
  localparam int COL_W = clog2(IMG_W);

  logic [PIX_W-1:0] r_lb0 [IMG_W];
  logic [PIX_W-1:0] r_lb1 [IMG_W];
  logic [PIX_W-1:0] r_win [3][3];
  logic [PIX_W-1:0] w_new [3];

  // lb0 holds the row above at each column, lb1 the row two above
  assign w_new[0] = r_lb1[i_col];
  assign w_new[1] = r_lb0[i_col];
  assign w_new[2] = i_pix;

  for (genvar i = 0; i < IMG_W; i++) begin : g_col
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_lb0[i] <= '0;
        r_lb1[i] <= '0;
      end else if (i_shift) begin
        if (i_sof) begin
          r_lb0[i] <= (i == 0) ? i_pix : '0;
          r_lb1[i] <= '0;
        end else if (i_col == COL_W'(i)) begin
          r_lb1[i] <= r_lb0[i];
          r_lb0[i] <= i_pix;
        end
      end
    end
  end

  for (genvar y = 0; y < 3; y++) begin : g_row
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_win[y][0] <= '0;
        r_win[y][1] <= '0;
        r_win[y][2] <= '0;
      end else if (i_shift) begin
        if (i_sof) begin
          r_win[y][0] <= '0;
          r_win[y][1] <= '0;
          r_win[y][2] <= (y == 2) ? i_pix : '0;
        end else begin
          r_win[y][0] <= r_win[y][1];
          r_win[y][1] <= r_win[y][2];
          r_win[y][2] <= w_new[y];
        end
      end
    end
    for (genvar x = 0; x < 3; x++) begin : g_tap
      assign o_win[(y*3+x)*PIX_W +: PIX_W] = r_win[y][x];
    end
  end

endmodule

// File: rtl/conv3x3_stream_layer.sv
// rtl/conv3x3_stream_layer.sv - streaming 3x3 valid-padding conv layer, one output channel per cycle
// CONV_RELU_EN (in conv_pkg::sat_res) selects fused ReLU over signed saturation.
module conv3x3_stream_layer import conv_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int IN_CH  = 3,
  parameter int OUT_CH = 9,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int SHIFT  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wgt_we,
  input  logic [ADDR_W-1:0]          wgt_addr,
  input  logic [DATA_W-1:0]          wgt_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic [IN_CH*DATA_W-1:0]    in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_CH*DATA_W-1:0]   out_data,
  output logic                       out_sof,
  output logic                       frame_done,
  output logic                       busy
);
  localparam int TAPS_N = IN_CH * TAPS;
  localparam int NW     = wgt_count(IN_CH, OUT_CH);
  localparam int ACC_W  = acc_width(DATA_W, IN_CH);
  localparam int SUM_W  = ACC_W + SHIFT + 1;
  localparam int PW     = 2 * DATA_W + 1;
  localparam int COL_W  = clog2(IMG_W);
  localparam int ROW_W  = clog2(IMG_H);
  localparam int OC_W   = (OUT_CH > 1) ? clog2(OUT_CH) : 1;

  state_t                    r_state;
  logic                      r_in_ready, r_out_valid, r_out_sof, r_frame_done, r_busy;
  logic [OUT_CH*DATA_W-1:0]  r_out_data;
  logic [ROW_W-1:0]          r_row;
  logic [COL_W-1:0]          r_col;
  logic [OC_W-1:0]           r_oc;
  logic                      r_sof_pend, r_last_pend;

  logic signed [DATA_W-1:0]  r_wgt  [OUT_CH][TAPS_N];
  logic signed [DATA_W-1:0]  r_bias [OUT_CH];

  logic                      w_xfer, w_win_ok;
  logic [ROW_W-1:0]          w_row;
  logic [COL_W-1:0]          w_col;
  logic [TAPS*IN_CH*DATA_W-1:0] w_win;
  logic signed [PW-1:0]      w_prod [TAPS_N];
  logic signed [ACC_W-1:0]   w_psum [TAPS_N+1];
  logic signed [SUM_W-1:0]   w_sum, w_res;
  logic [DATA_W-1:0]         w_q;

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_sof    = r_out_sof;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

  // in_sof relocates the transferred pixel to the frame origin
  assign w_xfer   = in_valid & r_in_ready;
  assign w_row    = in_sof ? '0 : r_row;
  assign w_col    = in_sof ? '0 : r_col;
  assign w_win_ok = (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));

  line_window_buf #(.DATA_W(DATA_W), .IN_CH(IN_CH), .IMG_W(IMG_W)) u_lwb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_shift (w_xfer),
    .i_sof   (in_sof),
    .i_col   (w_col),
    .i_pix   (in_data),
    .o_win   (w_win)
  );

  for (genvar oc = 0; oc < OUT_CH; oc++) begin : g_woc
    for (genvar j = 0; j < TAPS_N; j++) begin : g_wtap
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wgt[oc][j] <= '0;
        else if (wgt_we && (wgt_addr == ADDR_W'(oc*TAPS_N + j))) r_wgt[oc][j] <= wgt_data;
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_bias[oc] <= '0;
      else if (wgt_we && (wgt_addr == ADDR_W'(NW + oc))) r_bias[oc] <= wgt_data;
    end
  end

  // tap j = ic*9 + ky*3 + kx matches the weight address layout
  for (genvar ic = 0; ic < IN_CH; ic++) begin : g_ic
    for (genvar k = 0; k < TAPS; k++) begin : g_k
      logic signed [PW-1:0] w_px, w_wt;
      assign w_px = PW'($signed({1'b0, w_win[(k*IN_CH+ic)*DATA_W +: DATA_W]}));
      assign w_wt = PW'(r_wgt[r_oc][ic*TAPS+k]);
      assign w_prod[ic*TAPS+k] = w_px * w_wt;
    end
  end

  assign w_psum[0] = '0;
  for (genvar j = 0; j < TAPS_N; j++) begin : g_sum
    assign w_psum[j+1] = w_psum[j] + ACC_W'(w_prod[j]);
  end

  assign w_sum = SUM_W'(w_psum[TAPS_N]) + (SUM_W'(r_bias[r_oc]) <<< SHIFT);
  assign w_res = w_sum >>> SHIFT;
  assign w_q   = DATA_W'(sat_res(64'(w_res), DATA_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ACCEPT;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sof    <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_oc         <= '0;
      r_sof_pend   <= 1'b0;
      r_last_pend  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ACCEPT: begin
          if (w_xfer) begin
            if (w_col == COL_W'(IMG_W-1)) begin
              r_col <= '0;
              r_row <= (w_row == ROW_W'(IMG_H-1)) ? '0 : w_row + ROW_W'(1);
            end else begin
              r_col <= w_col + COL_W'(1);
              r_row <= w_row;
            end
            if (w_win_ok) begin
              r_state     <= COMPUTE;
              r_in_ready  <= 1'b0;
              r_busy      <= 1'b1;
              r_oc        <= '0;
              r_sof_pend  <= (w_row == ROW_W'(2)) && (w_col == COL_W'(2));
              r_last_pend <= (w_row == ROW_W'(IMG_H-1)) && (w_col == COL_W'(IMG_W-1));
            end
          end
        end
        COMPUTE: begin
          r_out_data[r_oc*DATA_W +: DATA_W] <= w_q;
          if (r_oc == OC_W'(OUT_CH-1)) begin
            r_state     <= OUTPUT;
            r_out_valid <= 1'b1;
            r_out_sof   <= r_sof_pend;
          end else begin
            r_oc <= r_oc + OC_W'(1);
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            r_state      <= ACCEPT;
            r_out_valid  <= 1'b0;
            r_out_sof    <= 1'b0;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= r_last_pend;
          end
        end
        default: r_state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_layer.sv
// tb/tb_conv3x3_stream_layer.sv - randomized self-checking bench against a frame-array convolution model
// Model honours CONV_RELU_EN the same way the design does.
module tb_conv3x3_stream_layer;
  localparam int DATA_W = 8, IN_CH = 3, OUT_CH = 9, IMG_W = 16, IMG_H = 16, SHIFT = 4, ADDR_W = 10;
  localparam int TAPS_N = IN_CH * 9;
  localparam int NW     = OUT_CH * TAPS_N;
  localparam int PIX_W  = IN_CH * DATA_W;
  localparam int OUT_W  = OUT_CH * DATA_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wgt_we = 1'b0;
  logic [ADDR_W-1:0]  wgt_addr = '0;
  logic [DATA_W-1:0]  wgt_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_sof = 1'b0;
  logic [PIX_W-1:0]   in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [OUT_W-1:0]   out_data;
  logic               out_sof;
  logic               frame_done;
  logic               busy;

  always #5 clk = ~clk;

  conv3x3_stream_layer #(
    .DATA_W(DATA_W), .IN_CH(IN_CH), .OUT_CH(OUT_CH), .IMG_W(IMG_W),
    .IMG_H(IMG_H), .SHIFT(SHIFT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .frame_done(frame_done), .busy(busy)
  );

  int checks = 0, failures = 0;
  int m_w [OUT_CH][TAPS_N];
  int m_b [OUT_CH];
  logic [PIX_W-1:0] img [IMG_H][IMG_W];
  int mrow = 0, mcol = 0;
  int n_sof = 0, n_fd = 0, n_out = 0, g_hold = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int oc = 0; oc < OUT_CH; oc++) begin
      m_b[oc] = 0;
      for (int j = 0; j < TAPS_N; j++) m_w[oc][j] = 0;
    end
    mrow = 0;
    mcol = 0;
  endtask

  task automatic wr(input int addr, input int val);
    logic signed [DATA_W-1:0] sv;
    sv = DATA_W'(val);
    wgt_we = 1'b1;
    wgt_addr = ADDR_W'(addr);
    wgt_data = sv;
    @(posedge clk); #1;
    wgt_we = 1'b0;
    if (addr < NW) m_w[addr / TAPS_N][addr % TAPS_N] = int'(sv);
    else if (addr < NW + OUT_CH) m_b[addr - NW] = int'(sv);
  endtask

  function automatic logic [OUT_W-1:0] expect_vec(input int r, input int c);
    logic [OUT_W-1:0] v;
    logic [PIX_W-1:0] p;
    logic [DATA_W-1:0] px;
    int acc, res, lo, hi;
`ifdef CONV_RELU_EN
    lo = 0;
    hi = (1 << DATA_W) - 1;
`else
    lo = -(1 << (DATA_W - 1));
    hi = (1 << (DATA_W - 1)) - 1;
`endif
    v = '0;
    for (int oc = 0; oc < OUT_CH; oc++) begin
      acc = 0;
      for (int ic = 0; ic < IN_CH; ic++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            p  = img[r-2+ky][c-2+kx];
            px = p[ic*DATA_W +: DATA_W];
            acc += int'(px) * m_w[oc][ic*9 + ky*3 + kx];
          end
      res = (acc + m_b[oc] * (1 << SHIFT)) >>> SHIFT;
      if (res > hi) res = hi;
      if (res < lo) res = lo;
      v[oc*DATA_W +: DATA_W] = res[DATA_W-1:0];
    end
    return v;
  endfunction

  task automatic send_pixel(input logic [PIX_W-1:0] d, input logic sof);
    int n, er, ec;
    logic exp_out;
    logic [OUT_W-1:0] ev, held;
    if (sof) begin mrow = 0; mcol = 0; end
    img[mrow][mcol] = d;
    er = mrow;
    ec = mcol;
    exp_out = (er >= 2) && (ec >= 2);
    if (mcol == IMG_W - 1) begin
      mcol = 0;
      mrow = (mrow == IMG_H - 1) ? 0 : mrow + 1;
    end else mcol++;
    in_data = d;
    in_sof = sof;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    if (exp_out) begin
      ev = expect_vec(er, ec);
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("latency", n, OUT_CH);
      if (g_hold > 0) begin
        held = out_data;
        for (int i = 0; i < g_hold; i++) begin @(posedge clk); #1; end
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held);
        check("hold_in_ready", in_ready, 0);
        g_hold = 0;
      end
      check("out_data", out_data, ev);
      check("out_sof", out_sof, (er == 2 && ec == 2));
      if (out_sof) n_sof++;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_out++;
      check("frame_done", frame_done, (er == IMG_H - 1 && ec == IMG_W - 1));
      if (frame_done) n_fd++;
      check("one_handshake", out_valid, 0);
    end else begin
      check("no_window_ready", in_ready, 1);
    end
  endtask

  function automatic logic [PIX_W-1:0] gen_pix(input int mode, input int c);
    logic [PIX_W-1:0] d;
    d = PIX_W'($urandom);
    if (mode == 1) d[DATA_W-1:0] = DATA_W'(c);
    if (mode == 2) d = '1;
    return d;
  endfunction

  task automatic send_rows(input int nrows, input int mode, input logic first_sof);
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < IMG_W; c++)
        send_pixel(gen_pix(mode, c), first_sof && r == 0 && c == 0);
  endtask

  task automatic load_weights(input int mode);
    for (int oc = 0; oc < OUT_CH; oc++)
      for (int j = 0; j < TAPS_N; j++) begin
        case (mode)
          0: wr(oc*TAPS_N + j, (j == 4) ? 16 : 0);
          1: wr(oc*TAPS_N + j, 1);
          2: wr(oc*TAPS_N + j, -1);
          default: wr(oc*TAPS_N + j, int'($urandom_range(8)) - 4);
        endcase
      end
    for (int oc = 0; oc < OUT_CH; oc++)
      wr(NW + oc, (mode == 3) ? int'($urandom_range(255)) - 128 : 0);
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // bias-only frame
    for (int oc = 0; oc < OUT_CH; oc++) wr(NW + oc, oc);
    wr(NW + OUT_CH + 3, 77);
    n_sof = 0; n_fd = 0; n_out = 0;
    send_rows(IMG_H, 0, 1'b1);
    check("t1_outputs", n_out, (IMG_W - 2) * (IMG_H - 2));
    check("t1_sof_count", n_sof, 1);
    check("t1_fd_count", n_fd, 1);

    // centre-tap echo on a column ramp
    load_weights(0);
    send_rows(3, 1, 1'b1);

    // saturation both directions
    load_weights(1);
    send_rows(3, 2, 1'b1);
    load_weights(2);
    send_rows(3, 2, 1'b1);

    // random weights and biases, back-pressure on first output
    load_weights(3);
    g_hold = 20;
    n_sof = 0; n_fd = 0;
    send_rows(IMG_H, 0, 1'b1);
    check("t4_sof_count", n_sof, 1);
    check("t4_fd_count", n_fd, 1);

    // restart mid-frame at what would be pixel (5,7)
    send_rows(5, 0, 1'b1);
    for (int c = 0; c < 7; c++) send_pixel(gen_pix(0, c), 1'b0);
    n_sof = 0; n_fd = 0; n_out = 0;
    send_rows(IMG_H, 0, 1'b1);
    check("t5_outputs", n_out, (IMG_W - 2) * (IMG_H - 2));
    check("t5_sof_count", n_sof, 1);
    check("t5_fd_count", n_fd, 1);

    // reset while computing
    send_rows(2, 0, 1'b1);
    send_pixel(gen_pix(0, 0), 1'b0);
    send_pixel(gen_pix(0, 1), 1'b0);
    in_data = gen_pix(0, 2);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_out_data", out_data, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_clear();
    send_rows(3, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
